// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: per-channel synchronised edge-to-pulse generator with post-release holdoff.
// Optional auto-repeat while an input is held is enabled by defining PULSE_REPEAT_EN.
module pulse_gen_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned PULSE_LEN     = 1,
  parameter int unsigned HOLDOFF       = 0,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] flag,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] busy,
  output logic                any_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HELD, S_HOLDOFF} state_t;

  localparam int unsigned MAX_PH  = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int unsigned MAX_RP  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned MAX_ALL = (MAX_PH > MAX_RP) ? MAX_PH : MAX_RP;
  localparam int unsigned CW      = $clog2(MAX_ALL + 1);
  localparam bit          HAS_HOLD = (HOLDOFF > 0);
  localparam logic [CW-1:0] L_PULSE = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HAS_HOLD ? HOLDOFF - 1 : 0);
`ifdef PULSE_REPEAT_EN
  localparam logic [CW-1:0] L_DLY   = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] L_PER   = CW'(REPEAT_PERIOD - 1);
`endif

  logic [CHANNELS-1:0] w_pulse_nxt;
  logic [CHANNELS-1:0] w_busy_nxt;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic          w_flag_s;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
`ifdef PULSE_REPEAT_EN
    logic          r_rep, w_rep_nxt;
`endif

    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_flag_s = flag[gi];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= flag[gi];
          for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_flag_s = r_sync[SYNC_STAGES-1];
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
`ifdef PULSE_REPEAT_EN
      w_rep_nxt   = r_rep;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_flag_s) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = L_PULSE;
`ifdef PULSE_REPEAT_EN
            w_rep_nxt   = 1'b0;
`endif
          end
        end
        S_PULSE: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else if (w_flag_s) begin
            w_state_nxt = S_HELD;
`ifdef PULSE_REPEAT_EN
            w_cnt_nxt   = r_rep ? L_PER : L_DLY;
`endif
          end else if (HAS_HOLD) begin
            w_state_nxt = S_HOLDOFF;
            w_cnt_nxt   = L_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_HELD: begin
          if (!w_flag_s) begin
            if (HAS_HOLD) begin
              w_state_nxt = S_HOLDOFF;
              w_cnt_nxt   = L_HOLD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
`ifdef PULSE_REPEAT_EN
          else if (r_cnt == '0) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = L_PULSE;
            w_rep_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
`endif
        end
        S_HOLDOFF: begin
          // A bounce during holdoff goes to HELD, never straight to a pulse.
          if (w_flag_s) begin
            w_state_nxt = S_HELD;
`ifdef PULSE_REPEAT_EN
            w_cnt_nxt   = L_DLY;
            w_rep_nxt   = 1'b0;
`endif
          end else if (r_cnt == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
`ifdef PULSE_REPEAT_EN
        r_rep   <= 1'b0;
`endif
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
`ifdef PULSE_REPEAT_EN
        r_rep   <= w_rep_nxt;
`endif
      end
    end

    assign w_pulse_nxt[gi] = (w_state_nxt == S_PULSE);
    assign w_busy_nxt[gi]  = (w_state_nxt != S_IDLE);
  end

  // Outputs are registered from next-state so pulse, busy and any_pulse share one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse     <= '0;
      busy      <= '0;
      any_pulse <= 1'b0;
    end else begin
      pulse     <= w_pulse_nxt;
      busy      <= w_busy_nxt;
      any_pulse <= |w_pulse_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed self-checking bench for pulse_gen_multi across four parameterisations.
// Repeat expectations follow PULSE_REPEAT_EN as defined for the build.
module tb_pulse_gen_multi;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flag_a, flag_b, flag_c, flag_d;
  logic [3:0] pulse_a, pulse_b, pulse_c, pulse_d;
  logic [3:0] busy_a, busy_b, busy_c, busy_d;
  logic       any_a, any_b, any_c, any_d;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pulse_gen_multi #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(1), .HOLDOFF(0),
                    .REPEAT_DELAY(16), .REPEAT_PERIOD(8)) u_a (
    .clk(clk), .rst(rst), .flag(flag_a), .pulse(pulse_a), .busy(busy_a), .any_pulse(any_a));
  pulse_gen_multi #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(3), .HOLDOFF(0)) u_b (
    .clk(clk), .rst(rst), .flag(flag_b), .pulse(pulse_b), .busy(busy_b), .any_pulse(any_b));
  pulse_gen_multi #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(1), .HOLDOFF(4)) u_c (
    .clk(clk), .rst(rst), .flag(flag_c), .pulse(pulse_c), .busy(busy_c), .any_pulse(any_c));
  pulse_gen_multi #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(4), .HOLDOFF(4)) u_d (
    .clk(clk), .rst(rst), .flag(flag_d), .pulse(pulse_d), .busy(busy_d), .any_pulse(any_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    flag_a = 4'hF;
    repeat (3) tick();
    total++;
    if (pulse_a !== 4'h0 || busy_a !== 4'h0 || any_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got pulse=%b busy=%b any=%b exp 0000 0000 0", pulse_a, busy_a, any_a);
    end
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (pulse_a !== ((k == 3) ? 4'hF : 4'h0) || any_a !== (k == 3)) begin
        bad++;
        $display("FAIL reset_release k=%0d got pulse=%b any=%b exp pulse=%b any=%b",
                 k, pulse_a, any_a, (k == 3) ? 4'hF : 4'h0, (k == 3));
      end
    end
    flag_a = 4'h0;
    repeat (6) tick();
    total++;
    if (busy_a !== 4'h0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b exp 0000", busy_a);
    end
  endtask

  task automatic test_latency_width();
    logic [3:0] exp_p, exp_b;
    flag_b = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_p = (k >= 3 && k <= 5) ? 4'b0010 : 4'b0000;
      exp_b = (k >= 3) ? 4'b0010 : 4'b0000;
      total++;
      if (pulse_b !== exp_p || busy_b !== exp_b) begin
        bad++;
        $display("FAIL latency_width k=%0d got pulse=%b busy=%b exp pulse=%b busy=%b",
                 k, pulse_b, busy_b, exp_p, exp_b);
      end
    end
    flag_b = 4'b0000;
    repeat (6) tick();
    total++;
    if (busy_b !== 4'h0) begin
      bad++;
      $display("FAIL latency_idle got busy=%b exp 0000", busy_b);
    end
  endtask

  task automatic test_bounce();
    int npulse = 0;
    for (int i = 0; i < 39; i++) begin
      flag_c[0] = (i < 20) || (i == 22);
      tick();
      if (pulse_c[0] === 1'b1) npulse++;
    end
    total++;
    if (npulse != 1) begin
      bad++;
      $display("FAIL bounce_count got %0d pulses exp 1", npulse);
    end
    total++;
    if (busy_c !== 4'h0) begin
      bad++;
      $display("FAIL bounce_idle got busy=%b exp 0000", busy_c);
    end
    flag_c[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (pulse_c !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL bounce_retrigger k=%0d got pulse=%b exp %b",
                 k, pulse_c, (k == 3) ? 4'b0001 : 4'b0000);
      end
    end
    flag_c[0] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_mid_pulse_drop();
    logic [3:0] exp_p, exp_b;
    flag_d[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      flag_d[0] = 1'b0;
      exp_p = (k >= 3 && k <= 6) ? 4'b0001 : 4'b0000;
      exp_b = (k >= 3 && k <= 10) ? 4'b0001 : 4'b0000;
      total++;
      if (pulse_d !== exp_p || busy_d !== exp_b) begin
        bad++;
        $display("FAIL mid_pulse_drop k=%0d got pulse=%b busy=%b exp pulse=%b busy=%b",
                 k, pulse_d, busy_d, exp_p, exp_b);
      end
    end
  endtask

  task automatic test_parallel();
    logic [3:0] exp_p;
    flag_a = 4'b0101;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_p = (k == 3) ? 4'b0101 : 4'b0000;
      total++;
      if (pulse_a !== exp_p || any_a !== (k == 3) || busy_a[1] !== 1'b0 || busy_a[3] !== 1'b0) begin
        bad++;
        $display("FAIL parallel k=%0d got pulse=%b any=%b busy=%b exp pulse=%b any=%b busy[1,3]=0",
                 k, pulse_a, any_a, busy_a, exp_p, (k == 3));
      end
    end
    flag_a = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic test_repeat();
    logic [3:0] exp_p;
    flag_a[2] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      exp_p = 4'b0000;
      if (k == 3) exp_p = 4'b0100;
`ifdef PULSE_REPEAT_EN
      if (k == 20 || k == 29 || k == 38 || k == 47 || k == 56) exp_p = 4'b0100;
`endif
      total++;
      if (pulse_a !== exp_p) begin
        bad++;
        $display("FAIL repeat k=%0d got pulse=%b exp %b", k, pulse_a, exp_p);
      end
      flag_a[2] = (k < 60);
    end
    total++;
    if (busy_a !== 4'h0) begin
      bad++;
      $display("FAIL repeat_idle got busy=%b exp 0000", busy_a);
    end
  endtask

  task automatic test_reset_mid_pulse();
    flag_b = 4'b0001;
    repeat (4) tick();
    total++;
    if (pulse_b !== 4'b0001) begin
      bad++;
      $display("FAIL pre_reset_pulse got pulse=%b exp 0001", pulse_b);
    end
    rst = 1'b0;
    #1;
    total++;
    if (pulse_b !== 4'h0 || busy_b !== 4'h0 || any_b !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got pulse=%b busy=%b any=%b exp 0000 0000 0", pulse_b, busy_b, any_b);
    end
    repeat (2) tick();
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (pulse_b !== ((k >= 3 && k <= 5) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL reset_rerise k=%0d got pulse=%b exp %b",
                 k, pulse_b, (k >= 3 && k <= 5) ? 4'b0001 : 4'b0000);
      end
    end
    flag_b = 4'b0000;
    repeat (8) tick();
  endtask

  initial begin
    rst    = 1'b0;
    flag_a = 4'h0;
    flag_b = 4'h0;
    flag_c = 4'h0;
    flag_d = 4'h0;
    test_reset();
    test_latency_width();
    test_bounce();
    test_mid_pulse_drop();
    test_parallel();
    test_repeat();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
